// File: rtl/sa_pkg.sv
// Shared types and width helpers for the systolic-array result drain.
package sa_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND
    } state_t;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int res_w(input int width);
        return 2 * width;
    endfunction

    function automatic int row_w(input int hpe, input int width);
        return hpe * res_w(width);
    endfunction

endpackage

// File: rtl/sa_row_mux.sv
// Combinational selection of one row from the flat snapshot buffer.
module sa_row_mux
    import sa_pkg::*;
#(
    parameter int ROW_W = 64,
    parameter int VPE   = 4,
    localparam int IDX_W = clog2_min1(VPE)
) (
    input  logic [ROW_W*VPE-1:0] buf_i,
    input  logic [IDX_W-1:0]     sel_i,
    output logic [ROW_W-1:0]     row_o
);

    always_comb begin
        row_o = '0;
        for (int unsigned v = 0; v < VPE; v++) begin
            if (sel_i == IDX_W'(v)) begin
                row_o = buf_i[v*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: rtl/sa_result_drain.sv
// Snapshots the systolic-array result bus after a settle delay and streams it
// out one row per valid/ready beat.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int HPE   = 4,
    parameter int VPE   = 4,
    parameter int WIDTH = 8,
    parameter int DELAY = 3,
    localparam int RES_W     = res_w(WIDTH),
    localparam int ROW_W     = row_w(HPE, WIDTH),
    localparam int ROW_IDX_W = clog2_min1(VPE)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [RES_W*HPE*VPE-1:0]   YY,
    input  logic                       start,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [ROW_W-1:0]           out_data,
    output logic [ROW_IDX_W-1:0]       out_row,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       start_drop
);

    localparam int BUF_W = ROW_W * VPE;
    localparam int CNT_W = clog2_min1(DELAY + 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD = (DELAY > 0) ? CNT_W'(DELAY - 1) : '0;
    localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(VPE - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ROW_IDX_W-1:0]   row_q, row_d;
    logic [BUF_W-1:0]       buf_q, buf_d;
    logic                   done_q, done_d;
    logic                   drop_q, drop_d;

    logic [ROW_W-1:0]       row_data;
    logic                   send;
    logic                   hs;
    logic                   final_hs;
    logic                   accept;

    sa_row_mux #(
        .ROW_W (ROW_W),
        .VPE   (VPE)
    ) u_row_mux (
        .buf_i (buf_q),
        .sel_i (row_q),
        .row_o (row_data)
    );

    assign send     = (state_q == S_SEND);
    assign hs       = send & out_ready;
    assign final_hs = hs & (row_q == ROW_LAST);
    // A start coinciding with the last handshake chains straight into a new drain.
    assign accept   = start & ((state_q == S_IDLE) | final_hs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        drop_d  = drop_q | (start & ~accept & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                if (cnt_q == '0) begin
                    buf_d   = YY;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            if (DELAY == 0) begin
                buf_d   = YY;
                state_d = S_SEND;
            end else begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid  = send;
    assign out_data   = send ? row_data : '0;
    assign out_row    = row_q;
    assign out_last   = send & (row_q == ROW_LAST);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign start_drop = drop_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain (HPE=2, VPE=2, WIDTH=8, DELAY=3) with a
// cycle-time reference model compared on every cycle.
module tb_sa_result_drain;

    localparam int D  = 3;
    localparam int NV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] yy;
    logic        start;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [0:0]  out_row;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        start_drop;

    int n_checks = 0;
    int n_pass   = 0;
    logic en = 1'b0;

    sa_result_drain #(
        .HPE   (2),
        .VPE   (NV),
        .WIDTH (8),
        .DELAY (D)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .YY         (yy),
        .start      (start),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .start_drop (start_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a drain accepted at cycle t0 captures YY at the end of
    // cycle t0+D and presents beats from cycle t0+D+1 onward.
    int          cyc = 0;
    int          t0 = 0;
    int          sent = 0;
    logic        m_active = 1'b0;
    logic        m_done = 1'b0;
    logic        m_drop = 1'b0;
    logic [63:0] snap = '0;

    function automatic logic model_valid();
        return m_active && (cyc >= t0 + D + 1);
    endfunction

    always @(posedge clk) begin
        logic hs_m, fin_m, acc_m;
        hs_m = model_valid() && out_ready;
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_drop   = 1'b0;
            sent     = 0;
            snap     = '0;
        end else begin
            fin_m = hs_m && (sent == NV - 1);
            acc_m = start && (!m_active || fin_m);
            if (start && m_active && !fin_m) m_drop = 1'b1;
            if (m_active && D > 0 && cyc == t0 + D) snap = yy;
            if (hs_m) sent++;
            m_done = fin_m;
            if (fin_m) begin
                m_active = 1'b0;
                sent     = 0;
            end
            if (acc_m) begin
                m_active = 1'b1;
                t0       = cyc;
                sent     = 0;
                if (D == 0) snap = yy;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (en) begin
            check("valid", out_valid, model_valid());
            if (model_valid()) begin
                check("data", out_data, snap[sent*32 +: 32]);
                check("row", out_row, sent[0]);
                check("last", out_last, sent == NV - 1);
            end else begin
                check("last_idle", out_last, 1'b0);
            end
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("drop", start_drop, m_drop);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int k = 0;
        while (!out_valid && k < max_cyc) begin
            tick();
            k++;
        end
        check(name, out_valid, 1'b1);
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int k = 0;
        while (!done && k < max_cyc) begin
            tick();
            k++;
        end
        check(name, done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; yy = '0;
        tick(); tick();
        en = 1'b1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'h0);
        check("rst_row", out_row, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_drop", start_drop, 1'b0);
        rst = 1'b0;
        tick();

        // 1: basic drain, start in cycle 0
        yy = 64'h0004_0003_0002_0001;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("s1_not_yet", out_valid, 1'b0);
        tick();
        check("s1_valid_c4", out_valid, 1'b1);
        check("s1_row0", out_data, 32'h0002_0001);
        check("s1_idx0", out_row, 1'b0);
        tick();
        check("s1_row1", out_data, 32'h0004_0003);
        check("s1_last", out_last, 1'b1);
        tick();
        check("s1_done_c6", done, 1'b1);
        check("s1_busy_c6", busy, 1'b0);
        tick();

        // 2+3: backpressure and YY change after capture
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("s2_wait_valid", 10);
        yy = '1;
        for (int i = 0; i < 5; i++) begin
            check("s2_stall_data", out_data, 32'h0002_0001);
            check("s2_stall_row", out_row, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("s3_row1_isolated", out_data, 32'h0004_0003);
        check("s3_row1_idx", out_row, 1'b1);
        wait_done("s2_wait_done", 5);
        tick();

        // 4: start during SEND row 0 is dropped
        yy = 64'h0008_0007_0006_0005;
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("s4_wait_valid", 10);
        start = 1'b1; tick(); start = 1'b0;
        check("s4_drop_set", start_drop, 1'b1);
        check("s4_row0_held", out_data, 32'h0006_0005);
        out_ready = 1'b1;
        wait_done("s4_wait_done", 10);
        tick(); tick(); tick();
        check("s4_idle_busy", busy, 1'b0);
        check("s4_idle_valid", out_valid, 1'b0);
        check("s4_drop_sticky", start_drop, 1'b1);

        // 5: back-to-back start on the final handshake
        yy = 64'h0044_0033_0022_0011;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        check("s5_final_last", out_last, 1'b1);
        yy = 64'h00dd_00cc_00bb_00aa;
        start = 1'b1; tick(); start = 1'b0;
        check("s5_done", done, 1'b1);
        check("s5_busy", busy, 1'b1);
        wait_valid("s5_wait_valid2", 10);
        check("s5_second_row0", out_data, 32'h00bb_00aa);
        tick();
        check("s5_second_row1", out_data, 32'h00dd_00cc);
        wait_done("s5_wait_done2", 5);
        tick();

        // 6: reset during WAIT, then during SEND row 1
        yy = 64'h0006_0005_0004_0003;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("s6a_valid", out_valid, 1'b0);
        check("s6a_busy", busy, 1'b0);
        check("s6a_drop_cleared", start_drop, 1'b0);
        tick(); tick();
        check("s6a_no_resume", busy, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("s6b_wait_valid", 10);
        check("s6b_row0", out_data, 32'h0004_0003);
        tick();
        check("s6b_row1_idx", out_row, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("s6b_valid", out_valid, 1'b0);
        check("s6b_busy", busy, 1'b0);
        check("s6b_no_done", done, 1'b0);
        tick();
        check("s6b_no_done_late", done, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("s6c_wait_valid", 10);
        check("s6c_row0_idx", out_row, 1'b0);
        check("s6c_row0", out_data, 32'h0004_0003);
        tick();
        check("s6c_row1", out_data, 32'h0006_0005);
        tick();
        check("s6c_done", done, 1'b1);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
